// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch address width, opcode encodings, fetch FSM states.
package pipe_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [3:0] NOP_OP  = 4'h0;
  localparam logic [3:0] ALU_OP  = 4'h1;
  localparam logic [3:0] LD_OP   = 4'h2;
  localparam logic [3:0] ST_OP   = 4'h3;
  localparam logic [3:0] BR_OP   = 4'h8;
  localparam logic [3:0] JMP_OP  = 4'h9;
  localparam logic [3:0] HALT_OP = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && (r_value != MAX_VAL)) begin
      r_value <= r_value + W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address, handles stall/redirect,
// and drains the pipeline after a HALT before parking in HALTED.
module fetch_sequencer #(
  parameter int unsigned PC_W         = pipe_pkg::PC_W,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic [3:0]      rom_opcode,
  output logic [PC_W-1:0] pc,
  output logic            if_valid,
  output logic            flush,
  output logic            halted,
  output logic [1:0]      state,
  output logic [15:0]     fetch_count
);

  import pipe_pkg::fetch_state_t;
  import pipe_pkg::ST_IDLE;
  import pipe_pkg::ST_RUN;
  import pipe_pkg::ST_DRAIN;
  import pipe_pkg::ST_HALTED;
  import pipe_pkg::HALT_OP;

  localparam int unsigned       DRAIN_W    = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic [DRAIN_W-1:0]  w_drain_nxt;
  logic                r_halted;
  logic                w_if_valid;
  logic                w_flush;
  logic                w_cnt_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_halted    <= (w_state_nxt == ST_HALTED);
    end
  end

  // Redirect outranks stall and HALT detection in every active state.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drain_nxt = r_drain_cnt;
    w_if_valid  = 1'b0;
    w_flush     = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = start_pc;
          w_drain_nxt = '0;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          w_flush  = 1'b1;
          w_pc_nxt = redirect_pc;
        end else if (!stall) begin
          w_if_valid = 1'b1;
          if (rom_opcode == HALT_OP) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          w_flush     = 1'b1;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_RUN;
          w_drain_nxt = '0;
        end else begin
          // Stalls do not pause the drain window.
          w_drain_nxt = r_drain_cnt + DRAIN_W'(1);
          if (r_drain_cnt == DRAIN_LAST) begin
            w_state_nxt = ST_HALTED;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  sat_counter #(
    .W(16)
  ) u_fetch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (w_if_valid),
    .clr  (w_cnt_clr),
    .value(fetch_count)
  );

  assign pc       = r_pc;
  assign if_valid = w_if_valid;
  assign flush    = w_flush;
  assign halted   = r_halted;
  assign state    = 2'(r_state);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: accepted fetch addresses are scoreboarded,
// control outputs are checked step by step.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] start_pc;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [3:0]  rom_opcode;
  logic [15:0] pc;
  logic        if_valid;
  logic        flush;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] fetch_count;

  logic        sat_inc;
  logic        sat_clr;
  logic [3:0]  sat_val;

  int checks = 0;
  int errors = 0;
  logic [15:0] q_pc[$];

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(16), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_opcode(rom_opcode), .pc(pc), .if_valid(if_valid), .flush(flush),
    .halted(halted), .state(state), .fetch_count(fetch_count)
  );

  sat_counter #(.W(4)) u_sat4 (
    .clk(clk), .rst_n(rst_n), .inc(sat_inc), .clr(sat_clr), .value(sat_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Every accepted fetch must match the next address the stimulus predicted.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_valid === 1'b1) begin
      if (q_pc.size() == 0) begin
        chk("unexpected_fetch", 32'(pc), 32'hFFFF_FFFF);
      end else begin
        chk("fetch_pc", 32'(pc), 32'(q_pc.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_pc = '0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; rom_opcode = 4'h1; sat_inc = 1'b0; sat_clr = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(fetch_count), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    nxt();
    rst_n = 1'b1;

    // Scenario 1: start at 0x10, four clean fetches
    start = 1'b1; start_pc = 16'h0010;
    @(negedge clk);
    chk("idle_if_valid", 32'(if_valid), 0);
    nxt();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_pc.push_back(16'h0010 + 16'(i));
      @(negedge clk);
      chk("s1_pc", 32'(pc), 32'h10 + 32'(i));
      chk("s1_state", 32'(state), 1);
      nxt();
    end
    redirect = 1'b1; redirect_pc = 16'h0012;
    @(negedge clk);
    chk("s1_count", 32'(fetch_count), 4);
    chk("redir_flush", 32'(flush), 1);
    chk("redir_if_valid", 32'(if_valid), 0);
    nxt();
    redirect = 1'b0;

    // Scenario 2: stall two cycles at 0x12
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("s2_pc_hold", 32'(pc), 32'h12);
      chk("s2_if_valid", 32'(if_valid), 0);
      nxt();
    end
    stall = 1'b0;
    q_pc.push_back(16'h0012);
    @(negedge clk);
    chk("s2_count_hold", 32'(fetch_count), 4);
    nxt();
    q_pc.push_back(16'h0013);
    @(negedge clk);
    chk("s2_pc_adv", 32'(pc), 32'h13);
    nxt();

    // Scenario 3: redirect together with stall; start is ignored in RUN
    redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0040;
    start = 1'b1; start_pc = 16'h0099;
    @(negedge clk);
    chk("s3_flush", 32'(flush), 1);
    chk("s3_if_valid", 32'(if_valid), 0);
    nxt();
    redirect = 1'b0; stall = 1'b0;
    q_pc.push_back(16'h0040);
    @(negedge clk);
    chk("s3_pc", 32'(pc), 32'h40);
    chk("s3_state", 32'(state), 1);
    chk("s3_count", 32'(fetch_count), 6);
    nxt();
    start = 1'b0;
    q_pc.push_back(16'h0041);
    @(negedge clk);
    chk("s3_start_ignored_pc", 32'(pc), 32'h41);
    nxt();

    // Scenario 4: HALT at 0x20, three drain cycles, then restart at 0
    redirect = 1'b1; redirect_pc = 16'h0020;
    nxt();
    redirect = 1'b0; rom_opcode = 4'hE;
    q_pc.push_back(16'h0020);
    @(negedge clk);
    chk("s4_halt_fetch", 32'(if_valid), 1);
    nxt();
    rom_opcode = 4'h1;
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      start = (i == 2); start_pc = 16'h0077;
      @(negedge clk);
      chk("s4_drain_state", 32'(state), 2);
      chk("s4_drain_pc", 32'(pc), 32'h20);
      chk("s4_drain_if_valid", 32'(if_valid), 0);
      chk("s4_drain_halted", 32'(halted), 0);
      nxt();
    end
    stall = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("s4_halted_state", 32'(state), 3);
    chk("s4_halted", 32'(halted), 1);
    chk("s4_halted_pc", 32'(pc), 32'h20);
    chk("s4_halted_flush", 32'(flush), 0);
    nxt();
    start = 1'b1; start_pc = 16'h0000;
    nxt();
    start = 1'b0; stall = 1'b1;
    @(negedge clk);
    chk("s4_restart_state", 32'(state), 1);
    chk("s4_restart_pc", 32'(pc), 0);
    chk("s4_restart_count", 32'(fetch_count), 0);
    chk("s4_restart_halted", 32'(halted), 0);
    nxt();

    // Scenario 5: HALT, then redirect in the second drain cycle
    stall = 1'b0; rom_opcode = 4'hE;
    q_pc.push_back(16'h0000);
    nxt();
    rom_opcode = 4'h1;
    @(negedge clk);
    chk("s5_drain1", 32'(state), 2);
    nxt();
    redirect = 1'b1; redirect_pc = 16'h0030;
    @(negedge clk);
    chk("s5_flush", 32'(flush), 1);
    chk("s5_halted_a", 32'(halted), 0);
    nxt();
    redirect = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_state", 32'(state), 1);
      chk("s5_pc", 32'(pc), 32'h30);
      chk("s5_halted_b", 32'(halted), 0);
      nxt();
    end

    // Scenario 6a: wrap from 0xFFFF
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFF;
    nxt();
    redirect = 1'b0;
    q_pc.push_back(16'hFFFF);
    nxt();
    stall = 1'b1;
    @(negedge clk);
    chk("s6_wrap", 32'(pc), 0);
    nxt();

    // Scenario 6b: saturating counter held at all-ones (narrow instance)
    sat_clr = 1'b1;
    nxt();
    sat_clr = 1'b0; sat_inc = 1'b1;
    for (int i = 0; i < 14; i++) nxt();
    @(negedge clk);
    chk("sat_14", 32'(sat_val), 14);
    nxt();
    @(negedge clk);
    chk("sat_15", 32'(sat_val), 15);
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("sat_hold", 32'(sat_val), 15);
    sat_inc = 1'b0;
    nxt();

    // Scenario 6c: asynchronous reset in the middle of DRAIN
    stall = 1'b0; rom_opcode = 4'hE;
    q_pc.push_back(16'h0000);
    nxt();
    rom_opcode = 4'h1; redirect = 1'b1; redirect_pc = 16'h0055;
    #2;
    chk("s6_pre_rst_state", 32'(state), 2);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_state", 32'(state), 0);
    chk("s6_rst_pc", 32'(pc), 0);
    chk("s6_rst_flush", 32'(flush), 0);
    chk("s6_rst_if_valid", 32'(if_valid), 0);
    nxt();
    redirect = 1'b0;
    rst_n = 1'b1;
    nxt();
    @(negedge clk);
    chk("s6_post_state", 32'(state), 0);
    chk("s6_post_pc", 32'(pc), 0);
    chk("s6_post_halted", 32'(halted), 0);
    chk("s6_post_count", 32'(fetch_count), 0);

    chk("scoreboard_empty", 32'(q_pc.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 16: program counter width.
REQ-002 Parameter DRAIN_CYCLES, default 3: cycles allowed for older instructions to leave the pipeline after HALT is fetched.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin fetching at start_pc; honored only in IDLE or HALTED.
REQ-006 start_pc  input  PC_W  first fetch address when start is accepted.
REQ-007 stall  input  1  hazard hold: freeze pc and suppress fetch this cycle.
REQ-008 redirect  input  1  taken branch or jump from execute stage.
REQ-009 redirect_pc  input  PC_W  target address, valid with redirect.
REQ-010 rom_opcode  input  4  opcode field returned combinationally by the instruction ROM for the current pc.
REQ-011 pc  output  PC_W  registered fetch address driven to the instruction ROM.
REQ-012 if_valid  output  1  instruction at pc is accepted into IF/ID this cycle.
REQ-013 flush  output  1  squash IF/ID and ID/EX contents this cycle.
REQ-014 halted  output  1  registered; high in HALTED state.
REQ-015 state  output  2  current FSM state, for debug.
REQ-016 fetch_count  output  16  number of accepted fetches; saturating.

Function
REQ-017 States: IDLE, RUN, DRAIN, HALTED; encoded as 0, 1, 2, 3.
REQ-018 IDLE to RUN: on start; pc <= start_pc; fetch_count <= 0.
REQ-019 RUN, no redirect, no stall: if_valid=1; pc <= pc+1, wrapping all-ones to 0.
REQ-020 RUN with stall and no redirect: if_valid=0; pc and fetch_count hold.
REQ-021 Redirect in RUN or DRAIN: if_valid=0; flush=1; pc <= redirect_pc; next state RUN.
REQ-022 Redirect has priority over stall and over HALT detection in the same cycle.
REQ-023 flush is combinational and equals redirect gated by state RUN or DRAIN; flush=0 in IDLE and HALTED.
REQ-024 RUN with if_valid=1 and rom_opcode=HALT_OP (4'hE): HALT is accepted; pc holds; next state DRAIN; drain counter <= 0.
REQ-025 DRAIN: if_valid=0; counter increments each cycle, including stalled cycles; at counter = DRAIN_CYCLES-1 with no redirect, next state HALTED.
REQ-026 HALTED: halted=1; pc holds; start returns to RUN with pc <= start_pc and fetch_count cleared.
REQ-027 start is ignored in RUN and DRAIN.
REQ-028 fetch_count increments on each if_valid=1 cycle and saturates at 16'hFFFF.
REQ-029 Fetch latency: an address loaded into pc at edge N is presented to the ROM during cycle N+1; if_valid qualifies that same cycle.

Reset
REQ-030 Reset is asserted when rst_n=0 and acts immediately, independent of clk.
REQ-031 Reset values: state=IDLE, pc=0, halted=0, fetch_count=0, drain counter=0.
REQ-032 if_valid=0 and flush=0 while in reset.
REQ-033 Reset mid-DRAIN or mid-redirect abandons the operation; no pending redirect survives reset.

Structure
REQ-034 Shared package pipe_pkg holds: the opcode constants (including HALT_OP), the fetch_state_t enum, and PC_W.
REQ-035 One sub-module, sat_counter (width parameter, inc, clr, value), implements fetch_count.
REQ-036 The drain counter is inline, with width $clog2(DRAIN_CYCLES)+1.

Verification
REQ-037 Scenario 1: reset, then start with start_pc=16'h0010, no stalls, opcodes non-HALT; required: pc reads 10,11,12,13 on consecutive cycles; fetch_count=4.
REQ-038 Scenario 2: stall held 2 cycles at pc=16'h0012; required: pc stays 12, if_valid=0 for 2 cycles, then pc advances to 13.
REQ-039 Scenario 3: redirect and stall together with redirect_pc=16'h0040; required: flush=1 and if_valid=0 that cycle; pc=40 next cycle; state=RUN.
REQ-040 Scenario 4: rom_opcode=4'hE at pc=16'h0020, DRAIN_CYCLES=3; required: DRAIN for 3 cycles, then halted=1 with pc=20; start with start_pc=0 returns to RUN with pc=0.
REQ-041 Scenario 5: HALT fetched, then redirect to 16'h0030 in the 2nd DRAIN cycle; required: flush=1, state=RUN, pc=30, halted never asserts.
REQ-042 Scenario 6: pc=16'hFFFF fetched; required: pc wraps to 0. Separately, fetch_count preloaded near saturation holds at 16'hFFFF. Separately, rst_n dropped mid-DRAIN forces state=IDLE and pc=0 asynchronously.
